// File: rtl/piradip_sync_fifo_v2.sv
// ---------------------------------------------------------------------------
// piradip_sync_fifo_v2 -- portable single-clock FIFO (no vendor macro).
//
// Read modes (parameter FWFT):
//   0 : standard, registered read, dout/data_valid one edge after an
//       accepted read.
//   1 : first-word-fall-through, head word sits in an output stage;
//       empty = !stage valid, re pops the presented word.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   we, din             write enable / data (accepted iff we && !full)
//   re                  read enable / FWFT pop (accepted iff re && !empty)
//   dout                read data
//   full, empty         status (registered)
//   almost_full/_empty  count == DEPTH-1 / count == 1
//   prog_full/_empty    count >= / <= threshold (threshold 0 disables)
//   count               words held, including the FWFT output stage
//   wr_ack              write accepted on previous edge
//   data_valid          dout holds a newly read word (FWFT: !empty)
//   overflow/underflow  write/read rejected on previous edge
//   parity_err          (PIRADIP_SYNC_FIFO_PARITY_EN only) word delivered
//                       to dout failed its even-parity check
//
// Optional feature macro: PIRADIP_SYNC_FIFO_PARITY_EN.
// With it defined, a bench may flip a bit of mem_q hierarchically to
// exercise parity_err.
// ---------------------------------------------------------------------------
module piradip_sync_fifo_v2 #(
    parameter int WIDTH             = 32,
    parameter int DEPTH             = 16,
    parameter int FWFT              = 0,
    parameter int PROG_FULL_THRESH  = 0,
    parameter int PROG_EMPTY_THRESH = 0,
    localparam int CW               = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             prog_full,
    output logic             prog_empty,
    output logic [CW-1:0]    count,
    output logic             wr_ack,
    output logic             data_valid,
    output logic             overflow,
`ifdef PIRADIP_SYNC_FIFO_PARITY_EN
    output logic             underflow,
    output logic             parity_err
`else
    output logic             underflow
`endif
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(DEPTH - 1);
    localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);
    localparam logic          PF_EN   = (PROG_FULL_THRESH != 0);
    localparam logic          PE_EN   = (PROG_EMPTY_THRESH != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ov_q, ov_d;          // FWFT output stage holds a word
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             dv_q, dv_d;
    logic             af_q, ae_q, pf_q, pe_q;
    logic             ack_q, ovf_q, udf_q;
    logic             wr_acc, rd_acc, mem_rd;

    always_comb begin
        wr_acc   = we && !full_q;
        rd_acc   = re && !empty_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        wr_ptr_d = wr_ptr_q + CW'(wr_acc);
        ov_d     = ov_q;
        dout_d   = dout_q;
        if (FWFT != 0) begin
            // Refill the output stage from the array whenever the array
            // holds a word and the stage is empty or being popped.
            mem_rd = (wr_ptr_q != rd_ptr_q) && (!ov_q || rd_acc);
            if (rd_acc) ov_d = 1'b0;
            if (mem_rd) ov_d = 1'b1;
        end else begin
            mem_rd = rd_acc;
        end
        rd_ptr_d = rd_ptr_q + CW'(mem_rd);
        if (mem_rd) dout_d = mem_q[rd_ptr_q[AW-1:0]];
        if (FWFT != 0) begin
            // The output stage counts as occupancy, so full comes from count.
            full_d  = (count_d == DEPTH_C);
            empty_d = !ov_d;
            dv_d    = ov_d;
        end else begin
            full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_d = (wr_ptr_d == rd_ptr_d);
            dv_d    = mem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ov_q     <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dv_q     <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b0;
            pf_q     <= 1'b0;
            pe_q     <= PE_EN;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ov_q     <= ov_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            dv_q     <= dv_d;
            af_q     <= (count_d == AF_C);
            ae_q     <= (count_d == CW'(1));
            pf_q     <= PF_EN && (count_d >= PF_C);
            pe_q     <= PE_EN && (count_d <= PE_C);
            ack_q    <= wr_acc;
            ovf_q    <= we && full_q;
            udf_q    <= re && empty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

`ifdef PIRADIP_SYNC_FIFO_PARITY_EN
    logic par_q [DEPTH];
    logic perr_q;

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) par_q[wr_ptr_q[AW-1:0]] <= ^din;
    end

    // Checked on the same read that loads dout, so the flag aligns with it.
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= mem_rd &&
                           ((^mem_q[rd_ptr_q[AW-1:0]]) != par_q[rd_ptr_q[AW-1:0]]);
    end

    assign parity_err = perr_q;
`endif

    assign dout         = dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign prog_full    = pf_q;
    assign prog_empty   = pe_q;
    assign count        = count_q;
    assign wr_ack       = ack_q;
    assign data_valid   = dv_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
